lcd_nibble_tx: RTL and testbench

- Physical-layer transmitter for an HD44780-class character LCD in 4-bit mode.
- Accepts whole bytes or single nibbles from an upstream sequencer over a valid/ready handshake.
- Splits each byte into high then low nibble and generates RS, D4..D7 and the E strobe with parameterised setup, pulse and hold timing.
- Inserts a post-transfer settle delay, lengthened automatically for clear and home commands, so the upstream sequencer never counts LCD timing itself.

---
 rtl/lcd_nibble_tx.sv | 185 ++++++++++++++++++
 tb/tb_lcd_nibble_tx.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx: HD44780 4-bit mode physical-layer transmitter.
// Splits bytes into high/low nibbles, generates RS, D4..D7 and the E strobe
// with parameterised setup/pulse/hold timing, then a settle wait that is
// lengthened for clear/home commands.
// Optional macro LCD_INIT_SEQ_EN: power-on wait followed by the 0x3,0x3,0x3,0x2
// wake-up nibble sequence before the upstream handshake is opened.
module lcd_nibble_tx #(
  parameter int E_HIGH_CYC       = 2,
  parameter int NIB_GAP_CYC      = 2,
  parameter int CMD_WAIT_CYC     = 50,
  parameter int LONG_WAIT_CYC    = 2000,
  parameter int POWERUP_WAIT_CYC = 20000,
  parameter int CW               = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic       IN_RS,
  input  logic       IN_NIBBLE,
  input  logic [7:0] IN_DATA,
  output logic       INIT_DONE,
  output logic       RS,
  output logic       E,
  output logic       D4,
  output logic       D5,
  output logic       D6,
  output logic       D7
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_GAP,
    ST_WAIT,
    ST_PWR
  } state_t;

  state_t        state;
  logic [CW-1:0] timer;
  logic [3:0]    nib;        // nibble currently on D7..D4
  logic [3:0]    lo_nib;     // low nibble waiting to follow the high one
  logic          last_nib;   // current nibble is the final one of the transfer
  logic          wait_long;  // clear/home command: use the long settle time
  logic [CW-1:0] wait_len;
  logic          finish;

`ifdef LCD_INIT_SEQ_EN
  logic          init_busy;
  logic [1:0]    init_idx;
`else
  logic          unused_powerup;
  assign unused_powerup = (POWERUP_WAIT_CYC != 0);
`endif

  assign {D7, D6, D5, D4} = nib;

  // Settle length for the transfer in flight
  always_comb begin
    wait_len = wait_long ? CW'(LONG_WAIT_CYC) : CW'(CMD_WAIT_CYC);
  end

  // End of a transfer: either the wait expired or a zero wait skips it entirely
  always_comb begin
    finish = ((state == ST_HOLD) && last_nib && (wait_len == '0)) ||
             ((state == ST_WAIT) && (timer == '0));
  end

  // Transfer FSM with registered LCD-side and handshake outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      timer     <= '0;
      E         <= 1'b0;
      RS        <= 1'b0;
      nib       <= '0;
      lo_nib    <= '0;
      last_nib  <= 1'b0;
      wait_long <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
      state     <= ST_PWR;
      timer     <= (POWERUP_WAIT_CYC > 0) ? CW'(POWERUP_WAIT_CYC - 1) : '0;
      IN_READY  <= 1'b0;
      INIT_DONE <= 1'b0;
      init_busy <= 1'b1;
      init_idx  <= '0;
`else
      state     <= ST_IDLE;
      IN_READY  <= 1'b1;
      INIT_DONE <= 1'b1;
`endif
    end else if (finish) begin
`ifdef LCD_INIT_SEQ_EN
      // Init nibbles reuse the normal SETUP/PULSE/HOLD/WAIT path back to back
      if (init_busy && (init_idx != 2'd3)) begin
        init_idx  <= init_idx + 2'd1;
        nib       <= (init_idx == 2'd2) ? 4'h2 : 4'h3;
        wait_long <= 1'b0;
        state     <= ST_SETUP;
      end else begin
        init_busy <= 1'b0;
        INIT_DONE <= 1'b1;
        IN_READY  <= 1'b1;
        state     <= ST_IDLE;
      end
`else
      IN_READY <= 1'b1;
      state    <= ST_IDLE;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (IN_VALID && IN_READY) begin
            RS        <= IN_RS;
            nib       <= IN_NIBBLE ? IN_DATA[3:0] : IN_DATA[7:4];
            lo_nib    <= IN_DATA[3:0];
            last_nib  <= IN_NIBBLE;
            wait_long <= !IN_RS && !IN_NIBBLE &&
                         ((IN_DATA == 8'h01) || (IN_DATA == 8'h02) || (IN_DATA == 8'h03));
            IN_READY  <= 1'b0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          E     <= 1'b1;
          timer <= CW'(E_HIGH_CYC - 1);
          state <= ST_PULSE;
        end
        ST_PULSE: begin
          if (timer == '0) begin
            E     <= 1'b0;
            state <= ST_HOLD;
          end else begin
            timer <= timer - CW'(1);
          end
        end
        ST_HOLD: begin
          if (!last_nib) begin
            if (NIB_GAP_CYC == 0) begin
              nib      <= lo_nib;
              last_nib <= 1'b1;
              state    <= ST_SETUP;
            end else begin
              timer <= CW'(NIB_GAP_CYC - 1);
              state <= ST_GAP;
            end
          end else begin
            timer <= wait_len - CW'(1);
            state <= ST_WAIT;
          end
        end
        ST_GAP: begin
          if (timer == '0) begin
            nib      <= lo_nib;
            last_nib <= 1'b1;
            state    <= ST_SETUP;
          end else begin
            timer <= timer - CW'(1);
          end
        end
        ST_WAIT: begin
          timer <= timer - CW'(1);
        end
        ST_PWR: begin
`ifdef LCD_INIT_SEQ_EN
          if (timer == '0) begin
            RS        <= 1'b0;
            nib       <= 4'h3;
            last_nib  <= 1'b1;
            wait_long <= 1'b1;
            state     <= ST_SETUP;
          end else begin
            timer <= timer - CW'(1);
          end
`else
          state <= ST_IDLE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_nibble_tx.sv
// tb_lcd_nibble_tx: directed bench for lcd_nibble_tx with default timing.
// Cycle k is the cycle ending at edge k; a transfer is offered in cycle 0 and
// accepted at edge 0. Outputs are sampled on the falling edge inside each cycle.
module tb_lcd_nibble_tx;

  logic       CLK;
  logic       RST;
  logic       IN_VALID;
  logic       IN_READY;
  logic       IN_RS;
  logic       IN_NIBBLE;
  logic [7:0] IN_DATA;
  logic       INIT_DONE;
  logic       RS;
  logic       E;
  logic       D4, D5, D6, D7;

  int tests;
  int fails;

  lcd_nibble_tx #(
    .E_HIGH_CYC      (2),
    .NIB_GAP_CYC     (2),
    .CMD_WAIT_CYC    (50),
    .LONG_WAIT_CYC   (2000),
    .POWERUP_WAIT_CYC(100),
    .CW              (16)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_RS    (IN_RS),
    .IN_NIBBLE(IN_NIBBLE),
    .IN_DATA  (IN_DATA),
    .INIT_DONE(INIT_DONE),
    .RS       (RS),
    .E        (E),
    .D4       (D4),
    .D5       (D5),
    .D6       (D6),
    .D7       (D7)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic test_reset();
    RST = 1'b1;
    IN_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    tests++;
    if (E !== 1'b0) begin fails++; $display("FAIL reset_E: got %b expected 0", E); end
    tests++;
    if (RS !== 1'b0) begin fails++; $display("FAIL reset_RS: got %b expected 0", RS); end
    tests++;
    if ({D7, D6, D5, D4} !== 4'h0) begin fails++; $display("FAIL reset_D: got %h expected 0", {D7, D6, D5, D4}); end
`ifdef LCD_INIT_SEQ_EN
    tests++;
    if (IN_READY !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", IN_READY); end
    tests++;
    if (INIT_DONE !== 1'b0) begin fails++; $display("FAIL reset_init_done: got %b expected 0", INIT_DONE); end
    RST = 1'b0;
`else
    tests++;
    if (IN_READY !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", IN_READY); end
    tests++;
    if (INIT_DONE !== 1'b1) begin fails++; $display("FAIL reset_init_done: got %b expected 1", INIT_DONE); end
    RST = 1'b0;
    @(negedge CLK);
    tests++;
    if (IN_READY !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %b expected 1", IN_READY); end
`endif
  endtask

`ifdef LCD_INIT_SEQ_EN
  // Offers a transfer throughout init; expects only the 3,3,3,2 nibbles
  task automatic test_init();
    logic [3:0] seen [8];
    int   npulse;
    logic prev_e;
    logic early_ready;
    logic done;
    npulse = 0;
    prev_e = 1'b0;
    early_ready = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 8; i++) seen[i] = 4'hF;
    IN_RS = 1'b1;
    IN_NIBBLE = 1'b0;
    IN_DATA = 8'h55;
    IN_VALID = 1'b1;
    for (int k = 0; k < 5000 && !done; k++) begin
      @(negedge CLK);
      if (E && !prev_e) begin
        if (npulse < 8) seen[npulse] = {D7, D6, D5, D4};
        npulse++;
        tests++;
        if (RS !== 1'b0) begin fails++; $display("FAIL init_rs: got %b expected 0", RS); end
      end
      prev_e = E;
      if (IN_READY && !INIT_DONE) early_ready = 1'b1;
      if (INIT_DONE === 1'b1) begin
        done = 1'b1;
        tests++;
        if (IN_READY !== 1'b1) begin fails++; $display("FAIL init_ready_with_done: got %b expected 1", IN_READY); end
        IN_VALID = 1'b0;
      end
    end
    IN_VALID = 1'b0;
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL init_timeout: got %b expected 1", done); end
    tests++;
    if (early_ready !== 1'b0) begin fails++; $display("FAIL init_early_ready: got %b expected 0", early_ready); end
    tests++;
    if (npulse != 4) begin fails++; $display("FAIL init_pulses: got %0d expected 4", npulse); end
    tests++;
    if (seen[0] !== 4'h3) begin fails++; $display("FAIL init_nib0: got %h expected 3", seen[0]); end
    tests++;
    if (seen[1] !== 4'h3) begin fails++; $display("FAIL init_nib1: got %h expected 3", seen[1]); end
    tests++;
    if (seen[2] !== 4'h3) begin fails++; $display("FAIL init_nib2: got %h expected 3", seen[2]); end
    tests++;
    if (seen[3] !== 4'h2) begin fails++; $display("FAIL init_nib3: got %h expected 2", seen[3]); end
  endtask
`endif

  // Full byte: E high at 2-3 (high nibble) and 8-9 (low nibble), ready at 11+wait
  task automatic test_byte(input logic rs, input logic [7:0] data);
    int   wl;
    int   rdy;
    int   npulse;
    logic prev_e;
    logic e_exp;
    wl = (!rs && (data == 8'h01 || data == 8'h02 || data == 8'h03)) ? 2000 : 50;
    rdy = 11 + wl;
    npulse = 0;
    prev_e = 1'b0;
    tests++;
    if (IN_READY !== 1'b1) begin fails++; $display("FAIL byte_start_ready: got %b expected 1", IN_READY); end
    IN_RS = rs;
    IN_NIBBLE = 1'b0;
    IN_DATA = data;
    IN_VALID = 1'b1;
    for (int k = 1; k <= rdy; k++) begin
      @(negedge CLK);
      if (k == 1) IN_VALID = 1'b0;
      e_exp = (k == 2 || k == 3 || k == 8 || k == 9);
      tests++;
      if (E !== e_exp) begin fails++; $display("FAIL byte_E_cyc%0d: got %b expected %b", k, E, e_exp); end
      if (k == 2 || k == 3) begin
        tests++;
        if ({D7, D6, D5, D4} !== data[7:4]) begin fails++; $display("FAIL byte_hi_D_cyc%0d: got %h expected %h", k, {D7, D6, D5, D4}, data[7:4]); end
        tests++;
        if (RS !== rs) begin fails++; $display("FAIL byte_RS_cyc%0d: got %b expected %b", k, RS, rs); end
      end
      if (k == 8 || k == 9) begin
        tests++;
        if ({D7, D6, D5, D4} !== data[3:0]) begin fails++; $display("FAIL byte_lo_D_cyc%0d: got %h expected %h", k, {D7, D6, D5, D4}, data[3:0]); end
      end
      if (E && !prev_e) npulse++;
      prev_e = E;
      if (k == rdy - 1) begin
        tests++;
        if (IN_READY !== 1'b0) begin fails++; $display("FAIL byte_busy_ready_cyc%0d: got %b expected 0", k, IN_READY); end
      end
      if (k == rdy) begin
        tests++;
        if (IN_READY !== 1'b1) begin fails++; $display("FAIL byte_ready_cyc%0d: got %b expected 1", k, IN_READY); end
      end
    end
    tests++;
    if (npulse != 2) begin fails++; $display("FAIL byte_pulses: got %0d expected 2", npulse); end
  endtask

  // Single nibble 0xA3: only 0x3 is strobed, ready at 55
  task automatic test_nibble();
    int   npulse;
    logic prev_e;
    logic e_exp;
    logic saw_hi;
    npulse = 0;
    prev_e = 1'b0;
    saw_hi = 1'b0;
    IN_RS = 1'b1;
    IN_NIBBLE = 1'b1;
    IN_DATA = 8'hA3;
    IN_VALID = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      @(negedge CLK);
      if (k == 1) IN_VALID = 1'b0;
      e_exp = (k == 2 || k == 3);
      tests++;
      if (E !== e_exp) begin fails++; $display("FAIL nib_E_cyc%0d: got %b expected %b", k, E, e_exp); end
      if (k == 2 || k == 3) begin
        tests++;
        if ({D7, D6, D5, D4} !== 4'h3) begin fails++; $display("FAIL nib_D_cyc%0d: got %h expected 3", k, {D7, D6, D5, D4}); end
      end
      if ({D7, D6, D5, D4} === 4'hA) saw_hi = 1'b1;
      if (E && !prev_e) npulse++;
      prev_e = E;
      if (k == 54) begin
        tests++;
        if (IN_READY !== 1'b0) begin fails++; $display("FAIL nib_busy_ready: got %b expected 0", IN_READY); end
      end
      if (k == 55) begin
        tests++;
        if (IN_READY !== 1'b1) begin fails++; $display("FAIL nib_ready: got %b expected 1", IN_READY); end
      end
    end
    IN_NIBBLE = 1'b0;
    tests++;
    if (npulse != 1) begin fails++; $display("FAIL nib_pulses: got %0d expected 1", npulse); end
    tests++;
    if (saw_hi !== 1'b0) begin fails++; $display("FAIL nib_hi_driven: got %b expected 0", saw_hi); end
  endtask

  // 0x41 then 0x42 with IN_VALID held; second accepted at edge 61, ready at 122
  task automatic test_back_to_back();
    int   npulse;
    logic prev_e;
    logic e_exp;
    npulse = 0;
    prev_e = 1'b0;
    IN_RS = 1'b1;
    IN_NIBBLE = 1'b0;
    IN_DATA = 8'h41;
    IN_VALID = 1'b1;
    for (int k = 1; k <= 122; k++) begin
      @(negedge CLK);
      if (k == 1) IN_DATA = 8'h42;
      if (k == 62) IN_VALID = 1'b0;
      if (k == 80 || k == 100) begin IN_VALID = 1'b1; IN_DATA = 8'hFF; end
      if (k == 81 || k == 101) IN_VALID = 1'b0;
      e_exp = (k == 2 || k == 3 || k == 8 || k == 9 ||
               k == 63 || k == 64 || k == 69 || k == 70);
      tests++;
      if (E !== e_exp) begin fails++; $display("FAIL b2b_E_cyc%0d: got %b expected %b", k, E, e_exp); end
      if (k == 8) begin
        tests++;
        if ({D7, D6, D5, D4} !== 4'h1) begin fails++; $display("FAIL b2b_first_lo: got %h expected 1", {D7, D6, D5, D4}); end
      end
      if (k == 63) begin
        tests++;
        if ({D7, D6, D5, D4} !== 4'h4) begin fails++; $display("FAIL b2b_second_hi: got %h expected 4", {D7, D6, D5, D4}); end
      end
      if (k == 69) begin
        tests++;
        if ({D7, D6, D5, D4} !== 4'h2) begin fails++; $display("FAIL b2b_second_lo: got %h expected 2", {D7, D6, D5, D4}); end
      end
      if (k == 60 || k == 62 || k == 121) begin
        tests++;
        if (IN_READY !== 1'b0) begin fails++; $display("FAIL b2b_busy_ready_cyc%0d: got %b expected 0", k, IN_READY); end
      end
      if (k == 61 || k == 122) begin
        tests++;
        if (IN_READY !== 1'b1) begin fails++; $display("FAIL b2b_ready_cyc%0d: got %b expected 1", k, IN_READY); end
      end
      if (E && !prev_e) npulse++;
      prev_e = E;
    end
    IN_VALID = 1'b0;
    tests++;
    if (npulse != 4) begin fails++; $display("FAIL b2b_pulses: got %0d expected 4", npulse); end
  endtask

  // Reset asserted while E is high aborts the byte; a following byte is normal
  task automatic test_rst_mid();
    logic done;
    IN_RS = 1'b1;
    IN_NIBBLE = 1'b0;
    IN_DATA = 8'h48;
    IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    @(negedge CLK);
    tests++;
    if (E !== 1'b1) begin fails++; $display("FAIL rst_mid_pre_E: got %b expected 1", E); end
    RST = 1'b1;
    @(negedge CLK);
    tests++;
    if (E !== 1'b0) begin fails++; $display("FAIL rst_mid_E: got %b expected 0", E); end
    tests++;
    if (RS !== 1'b0) begin fails++; $display("FAIL rst_mid_RS: got %b expected 0", RS); end
    tests++;
    if ({D7, D6, D5, D4} !== 4'h0) begin fails++; $display("FAIL rst_mid_D: got %h expected 0", {D7, D6, D5, D4}); end
`ifdef LCD_INIT_SEQ_EN
    tests++;
    if (IN_READY !== 1'b0) begin fails++; $display("FAIL rst_mid_ready: got %b expected 0", IN_READY); end
    RST = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 5000 && !done; k++) begin
      @(negedge CLK);
      if (INIT_DONE === 1'b1) done = 1'b1;
    end
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL rst_mid_init_timeout: got %b expected 1", done); end
`else
    done = 1'b1;
    tests++;
    if (IN_READY !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %b expected 1", IN_READY); end
    RST = 1'b0;
`endif
    if (done) test_byte(1'b1, 8'h48);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RST = 1'b1;
    IN_VALID = 1'b0;
    IN_RS = 1'b0;
    IN_NIBBLE = 1'b0;
    IN_DATA = 8'h00;
    test_reset();
`ifdef LCD_INIT_SEQ_EN
    test_init();
`endif
    test_byte(1'b1, 8'h48);
    test_byte(1'b0, 8'h01);
    test_nibble();
    test_back_to_back();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
